data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the pipeline's MEM-stage data-memory interface. It accepts the datapath's word address, store data and `mem_read`/`mem_write` strobes, and returns load data combinationally in the same cycle, as the MEM/WB register capture requires. Stores are absorbed into a small in-order store queue and retired into a single-port word RAM when the port is idle. Loads forward from the youngest matching queued store. `busy` is the only back-pressure toward the hazard unit.

## Interface
- `WORDS`, 1024, RAM depth in 32-bit words; power of two.
- `AW`, 10, index width; equals log2(`WORDS`).
- `WB_DEPTH`, 4, store-queue entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `adr`  in  32  byte address (EXMEM ALU result).
- `write_data`  in  32  store data.
- `mem_read`  in  1  load strobe.
- `mem_write`  in  1  store strobe.
- `read_data`  out  32  load data, combinational.
- `busy`  out  1  store not accepted this cycle; initiator must hold request.
- `wb_count`  out  log2(`WB_DEPTH`)+1  queued stores.

## Operation
- Index = `adr[AW+1:2]`. `adr[1:0]` and `adr[31:AW+2]` are ignored; out-of-range addresses alias modulo `WORDS`.
- `mem_read` and `mem_write` both high is illegal. If it occurs, it is treated as a write and `read_data` = 0.
- Load (`mem_read`=1, `mem_write`=0): `read_data` = data of the youngest queue entry whose index matches. With no match, `read_data` = `mem[index]`. With `mem_read`=0, `read_data` = 0.
- `full` = (`wb_count` == `WB_DEPTH`). `busy` = `mem_write` & `full`.
- Store accept: `mem_write` & !`busy` → at the edge, {index, `write_data`} is written at the tail and the tail advances.
- Drain: at the edge, if the queue is non-empty and `mem_read`=0 and (`mem_write`=0 or `full`), the head entry is written to `mem` and the head advances.
- Enqueue and drain in the same edge cannot happen: drain during a write happens only when `full`, and then the write is refused.
- Retirement order = acceptance order. Duplicate indices are not coalesced, so the last store wins in the RAM.
- Head and tail wrap modulo `WB_DEPTH`.

## Timing
- Load latency 0 cycles: `read_data` settles combinationally within the cycle the strobe is high.
- A store accepted at edge N is visible to a load in cycle N+1 via forwarding.
- A store reaches the RAM no earlier than the first edge after acceptance at which the drain condition holds.
- Full stall: a write presented while `full` sees `busy`=1 for exactly one cycle. The drain at that edge frees an entry, and the write is accepted at the next edge provided no load intervenes.
- Reset values: `wb_count`=0; head=tail=0; `busy`=0; `read_data`=0 while `mem_read`=0.
- RAM contents are not reset.
- Reset mid-operation: queued, unretired stores are discarded. Already-drained words persist.

## Structure
- Shared package `dmem_pkg`:
  - `WORD_W`=32.
  - Default `WORDS`, `WB_DEPTH`.
  - Typedef `sq_entry_t` {index[AW-1:0], data[31:0]}.
- Sub-module `store_queue`:
  - Circular FIFO of `sq_entry_t` with head/tail/count and enq/deq strobes.
  - Combinational associative lookup port (index in → hit, youngest data out). The priority search runs from tail-1 backward to head.
- Top level holds the RAM array, drain/accept decode, and the output mux.

## Test plan
- Reset; write 0x100 ← 0xDEADBEEF; next cycle read 0x100 → 0xDEADBEEF with `wb_count`=1 (forwarded). One idle cycle → `wb_count`=0; read 0x100 → 0xDEADBEEF from RAM.
- Writes 0x40 ← 1 then 0x40 ← 2 back-to-back, then read 0x40 → 2 with `wb_count`=2. Idle until empty; read 0x40 → 2.
- Five consecutive writes to 0x0,0x4,…,0x10:
  - `wb_count` reaches 4; fifth write sees `busy`=1 for one cycle while `wb_count` drops to 3.
  - Fifth write is accepted next cycle; `wb_count`=4.
  - After draining, all five addresses read back correctly.
- Continuous reads after 2 stores: `wb_count` stays 2 for every read cycle. It reaches 0 exactly two idle cycles after reads stop.
- Alias: write 0x1000 ← 0xA5 with `WORDS`=1024; read 0x0 → 0xA5.
- Write 0x8 ← 7 then assert `rst` before any idle cycle → `wb_count`=0, `busy`=0. Read 0x8 returns the pre-existing RAM value, not 7.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: word width, default RAM/queue geometry, the store-queue entry
// type and a helper for the queue occupancy width.
package dmem_pkg;

  localparam int WORD_W       = 32;
  localparam int DEF_WORDS    = 1024;
  localparam int DEF_AW       = 10;
  localparam int DEF_WB_DEPTH = 4;

  // The index field is sized for the default RAM depth. The top level
  // zero-extends its index into it, so AW must not exceed DEF_AW.
  typedef struct packed {
    logic [DEF_AW-1:0] index;
    logic [WORD_W-1:0] data;
  } sq_entry_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bus between the datapath (master) and responder (slave).
// Latency: read_data/busy are combinational from the request in the same cycle.
// Backpressure: busy=1 means the store was refused; master holds the request.
//
// Signals: adr (byte address), write_data, mem_read, mem_write toward the
// responder; read_data, busy, wb_count back to the datapath/hazard unit.
interface data_mem_responder_if #(
  parameter int WB_DEPTH = dmem_pkg::DEF_WB_DEPTH
) ();
  import dmem_pkg::*;

  localparam int CW = cnt_w(WB_DEPTH);

  logic [WORD_W-1:0] adr;
  logic [WORD_W-1:0] write_data;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] read_data;
  logic              busy;
  logic [CW-1:0]     wb_count;

  modport master (
    output adr, write_data, mem_read, mem_write,
    input  read_data, busy, wb_count
  );

  modport slave (
    input  adr, write_data, mem_read, mem_write,
    output read_data, busy, wb_count
  );

endinterface

// File: rtl/data_mem_responder_store_queue.sv
// In-order circular store queue with a combinational youngest-match lookup.
// Latency: enq/deq take effect at the clock edge; lookup is combinational.
// Backpressure: exposes full/empty; enq while full and deq while empty are ignored.
//
// Ports: clk, rst (sync, active-high); enq/enq_entry push at the tail;
// deq pops head_entry; count/full/empty status; lookup_index -> hit/hit_data.
module store_queue import dmem_pkg::*; #(
  parameter int DEPTH = DEF_WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq,
  input  sq_entry_t              enq_entry,
  input  logic                   deq,
  output sq_entry_t              head_entry,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                   full,
  output logic                   empty,
  input  logic [DEF_AW-1:0]      lookup_index,
  output logic                   hit,
  output logic [WORD_W-1:0]      hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sq_entry_t     entries_q [DEPTH];
  sq_entry_t     entries_d [DEPTH];

  logic          enq_ok;
  logic          deq_ok;
  logic [PW-1:0] slot;

  always_comb begin
    full   = (count_q == CW'(DEPTH));
    empty  = (count_q == '0);
    enq_ok = enq & ~full;
    deq_ok = deq & ~empty;
  end

  // Pointer and occupancy update; DEPTH is a power of two so the pointers
  // wrap by natural overflow.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (enq_ok) begin
      entries_d[tail_q] = enq_entry;
      tail_d            = tail_q + 1'b1;
    end
    if (deq_ok) begin
      head_d = head_q + 1'b1;
    end
    case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads need no reset: only slots inside [head, tail) are ever read.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // Priority search from the youngest entry (tail-1) back toward head; the
  // first valid match wins so a later store to the same word shadows older ones.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = tail_q - PW'(i + 1);
      if (!hit && (CW'(i) < count_q) && (entries_q[slot].index == lookup_index)) begin
        hit      = 1'b1;
        hit_data = entries_q[slot].data;
      end
    end
  end

  always_comb begin
    head_entry = entries_q[head_q];
    count      = count_q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: word RAM fronted by an in-order store queue.
// Latency: loads return combinationally in the request cycle; stores retire later.
// Backpressure: busy = mem_write while the store queue is full; drain frees a slot that edge.
//
// Ports: clk, rst (sync, active-high); bus (slave modport) carries adr,
// write_data, mem_read, mem_write in and read_data, busy, wb_count out.
module data_mem_responder import dmem_pkg::*; #(
  parameter int WORDS    = DEF_WORDS,
  parameter int AW       = DEF_AW,
  parameter int WB_DEPTH = DEF_WB_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int CW = cnt_w(WB_DEPTH);

  logic [AW-1:0]     idx;
  logic              rd_only;
  logic              enq;
  logic              deq;
  logic              full;
  logic              empty;
  logic              hit;
  logic [WORD_W-1:0] hit_data;
  logic [CW-1:0]     count;
  sq_entry_t         enq_entry;
  sq_entry_t         head_entry;

  // Retired store data; contents deliberately survive reset.
  logic [WORD_W-1:0] ram [WORDS];

  always_comb begin
    // Byte offset and address bits above the RAM are dropped, so
    // out-of-range addresses alias modulo WORDS.
    idx     = bus.adr[AW+1:2];
    // Read and write together is treated as a write with no load data.
    rd_only = bus.mem_read & ~bus.mem_write;

    enq_entry.index = DEF_AW'(idx);
    enq_entry.data  = bus.write_data;

    enq = bus.mem_write & ~full;
    // The RAM port is free whenever no load is using it. A pending write only
    // yields the port when it is being refused (full), so enq and deq are
    // mutually exclusive. Reset suppresses retirement so discarded stores
    // never reach the RAM.
    deq = ~empty & ~bus.mem_read & (~bus.mem_write | full) & ~rst;
  end

  store_queue #(
    .DEPTH (WB_DEPTH)
  ) u_store_queue (
    .clk          (clk),
    .rst          (rst),
    .enq          (enq),
    .enq_entry    (enq_entry),
    .deq          (deq),
    .head_entry   (head_entry),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .lookup_index (DEF_AW'(idx)),
    .hit          (hit),
    .hit_data     (hit_data)
  );

  always_ff @(posedge clk) begin
    if (deq) begin
      ram[AW'(head_entry.index)] <= head_entry.data;
    end
  end

  always_comb begin
    bus.busy      = bus.mem_write & full;
    bus.wb_count  = count;
    bus.read_data = '0;
    if (rd_only) begin
      bus.read_data = hit ? hit_data : ram[idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int D = 4;
  localparam int W = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if #(.WB_DEPTH(D)) bus ();

  data_mem_responder #(
    .WORDS    (W),
    .AW       (10),
    .WB_DEPTH (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } mq_t;
  mq_t         mq[$];             // stores accepted but not yet in RAM, oldest first
  logic [31:0] ram_m[int unsigned]; // RAM words whose content is known

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.adr        = a;
    bus.write_data = wd;
  endtask

  // One cycle: drive, compare outputs against the model, advance the model.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input string tag);
    int unsigned idx;
    bit          is_full;
    bit          known;
    logic [31:0] e;
    mq_t         m;
    @(negedge clk);
    drive(rd, wr, a, wd);
    #1;
    idx     = (a / 4) % W;
    is_full = (mq.size() == D);
    check({tag, "_busy"}, 32'(bus.busy), 32'(wr && is_full));
    check({tag, "_cnt"}, 32'(bus.wb_count), 32'(mq.size()));
    known = 1'b1;
    e     = '0;
    if (rd && !wr) begin
      known = 1'b0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].idx == idx) begin
          e     = mq[i].data;
          known = 1'b1;
          break;
        end
      end
      if (!known && ram_m.exists(idx)) begin
        e     = ram_m[idx];
        known = 1'b1;
      end
    end
    if (known) check({tag, "_rd"}, bus.read_data, e);
    if (wr && !is_full) begin
      m.idx  = idx;
      m.data = wd;
      mq.push_back(m);
    end else if (mq.size() > 0 && !rd && (!wr || is_full)) begin
      m = mq.pop_front();
      ram_m[m.idx] = m.data;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_busy;
    int          e_cnt;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] e_rd,
                              input logic e_busy, input int e_cnt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.adr = a; v.wd = wd;
    v.e_rd = e_rd; v.e_busy = e_busy; v.e_cnt = e_cnt;
    vt.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_cnt", 32'(bus.wb_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd", bus.read_data, 32'd0);
    rst = 1'b0;

    //   rd    wr    adr            wd             e_rd          busy cnt
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 0); // idle after reset
    add(1'b0, 1'b1, 32'h100,  32'hDEADBEEF,  32'h0,         1'b0, 0);
    add(1'b1, 1'b0, 32'h100,  32'h0,         32'hDEADBEEF,  1'b0, 1); // forwarded
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 1); // drains
    add(1'b1, 1'b0, 32'h100,  32'h0,         32'hDEADBEEF,  1'b0, 0); // from RAM
    add(1'b0, 1'b1, 32'h40,   32'h1,         32'h0,         1'b0, 0);
    add(1'b0, 1'b1, 32'h40,   32'h2,         32'h0,         1'b0, 1);
    add(1'b1, 1'b0, 32'h40,   32'h0,         32'h2,         1'b0, 2); // youngest wins
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 2);
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 1);
    add(1'b1, 1'b0, 32'h40,   32'h0,         32'h2,         1'b0, 0); // last store in RAM
    add(1'b0, 1'b1, 32'h0,    32'h11,        32'h0,         1'b0, 0);
    add(1'b0, 1'b1, 32'h4,    32'h12,        32'h0,         1'b0, 1);
    add(1'b0, 1'b1, 32'h8,    32'h13,        32'h0,         1'b0, 2);
    add(1'b0, 1'b1, 32'hC,    32'h14,        32'h0,         1'b0, 3);
    add(1'b0, 1'b1, 32'h10,   32'h15,        32'h0,         1'b1, 4); // full: refused, drains
    add(1'b0, 1'b1, 32'h10,   32'h15,        32'h0,         1'b0, 3); // held write accepted
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 4);
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 3);
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 2);
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 1);
    add(1'b1, 1'b0, 32'h0,    32'h0,         32'h11,        1'b0, 0);
    add(1'b1, 1'b0, 32'h4,    32'h0,         32'h12,        1'b0, 0);
    add(1'b1, 1'b0, 32'h8,    32'h0,         32'h13,        1'b0, 0);
    add(1'b1, 1'b0, 32'hC,    32'h0,         32'h14,        1'b0, 0);
    add(1'b1, 1'b0, 32'h10,   32'h0,         32'h15,        1'b0, 0);
    add(1'b0, 1'b1, 32'h20,   32'hA,         32'h0,         1'b0, 0);
    add(1'b0, 1'b1, 32'h24,   32'hB,         32'h0,         1'b0, 1);
    add(1'b1, 1'b0, 32'h20,   32'h0,         32'hA,         1'b0, 2); // reads block drain
    add(1'b1, 1'b0, 32'h24,   32'h0,         32'hB,         1'b0, 2);
    add(1'b1, 1'b0, 32'h0,    32'h0,         32'h11,        1'b0, 2);
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 2);
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 1);
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 0); // empty 2 idles later
    add(1'b0, 1'b1, 32'h1000, 32'hA5,        32'h0,         1'b0, 0); // aliases word 0
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 1);
    add(1'b1, 1'b0, 32'h3,    32'h0,         32'hA5,        1'b0, 0); // low bits ignored
    add(1'b1, 1'b1, 32'h0,    32'h99,        32'h0,         1'b0, 0); // both: a write
    add(1'b1, 1'b0, 32'h0,    32'h0,         32'h99,        1'b0, 1);
    add(1'b0, 1'b0, 32'h0,    32'h0,         32'h0,         1'b0, 1);
    add(1'b1, 1'b0, 32'h0,    32'h0,         32'h99,        1'b0, 0);

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rd, vt[i].wr, vt[i].adr, vt[i].wd);
      #1;
      check($sformatf("vec%0d_rd", i), bus.read_data, vt[i].e_rd);
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].e_busy));
      check($sformatf("vec%0d_cnt", i), 32'(bus.wb_count), 32'(vt[i].e_cnt));
    end

    // ---------------- hand sequences (model-checked) ----------------
    do_reset();
    ram_m.delete();

    // Reset discards a queued store; the previously drained word persists.
    step(1'b0, 1'b1, 32'h8, 32'h55, "pre");
    step(1'b0, 1'b0, 32'h0, 32'h0, "pre_drain");
    step(1'b0, 1'b1, 32'h8, 32'h7, "doomed");
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h8, 32'h7);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    mq.delete();
    #1;
    check("rst_mid_cnt", 32'(bus.wb_count), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    step(1'b1, 1'b0, 32'h8, 32'h0, "after_rst");
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    check("rst_discard_rd", bus.read_data, 32'h55);

    // Full stall with an intervening load, then duplicate indices in a full queue.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h80 + 32'(4 * i), 32'h100 + 32'(i), "fill");
    step(1'b0, 1'b1, 32'h90, 32'h200, "stall");
    step(1'b1, 1'b0, 32'h84, 32'h0, "stall_ld");
    step(1'b0, 1'b1, 32'h90, 32'h200, "stall_acc");
    step(1'b1, 1'b0, 32'h90, 32'h0, "stall_fwd");
    repeat (5) step(1'b0, 1'b0, 32'h0, 32'h0, "idle");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h44, 32'h300 + 32'(i), "dup");
    step(1'b1, 1'b0, 32'h44, 32'h0, "dup_rd");
    repeat (5) step(1'b0, 1'b0, 32'h0, 32'h0, "idle");

    // ---------------- randomized traffic over 16 words (+aliases) ----------------
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 32'(4 * i), $urandom, "init");
      step(1'b0, 1'b0, 32'h0, 32'h0, "init_dr");
    end
    for (int n = 0; n < 600; n++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 99);
      a   = (32'($urandom_range(0, 15)) + 32'(W) * 32'($urandom_range(0, 3))) * 4
            + 32'($urandom_range(0, 3));
      if (sel < 40)      step(1'b0, 1'b1, a, $urandom, "rnd_wr");
      else if (sel < 70) step(1'b1, 1'b0, a, $urandom, "rnd_rd");
      else if (sel < 75) step(1'b1, 1'b1, a, $urandom, "rnd_both");
      else               step(1'b0, 1'b0, a, $urandom, "rnd_idle");
    end
    repeat (6) step(1'b0, 1'b0, 32'h0, 32'h0, "tail_idle");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(4 * i), 32'h0, "final_rd");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
